// File: rtl/g_3strb_seq.sv
// Registered round-robin / broadcast active-low strobe sequencer with a request queue.
// Each accepted request yields a PULSE_W-cycle low strobe followed by GAP_W idle-high cycles.
module g_3strb_seq #(
  parameter int PULSE_W  = 2,
  parameter int GAP_W    = 1,
  parameter int PEND_MAX = 3
) (
  input  logic       CK,
  input  logic       CD,
  input  logic       Y,
  input  logic       BCAST,
  output logic       AN,
  output logic       BN,
  output logic       CN,
  output logic       BUSY,
  output logic       DONE,
  output logic       OVF,
  output logic [2:0] PEND
);
  typedef enum logic [1:0] {IDLE, STRB, GAP} state_t;

  localparam logic [3:0] PW_LAST = 4'(PULSE_W - 1);
  localparam logic [3:0] GW_LAST = 4'(GAP_W - 1);
  localparam logic [2:0] PMAX    = 3'(PEND_MAX);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [1:0] r_ptr;
  logic [2:0] r_strb_n;
  logic       r_busy, r_done, r_ovf;
  logic [2:0] r_pend;

  logic w_last_strb, w_last_gap, w_dec_pt, w_start, w_from_q, w_inc;

  assign w_last_strb = (r_state == STRB) && (r_cnt == PW_LAST);
  assign w_last_gap  = (r_state == GAP) && (r_cnt == GW_LAST);
  // Decision point: the cycle in which a new strobe may be launched.
  assign w_dec_pt    = (r_state == IDLE) || w_last_gap || (w_last_strb && (GAP_W == 0));
  assign w_start     = w_dec_pt && (Y || (r_pend != 3'd0));
  assign w_from_q    = w_start && (r_pend != 3'd0);
  // Y is queued unless it launched the strobe itself (queue empty at a decision point).
  assign w_inc       = Y && !(w_start && !w_from_q);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_start) begin
      w_state_nxt = STRB;
      w_cnt_nxt   = 4'd0;
    end else begin
      case (r_state)
        STRB: begin
          if (w_last_strb) begin
            w_state_nxt = (GAP_W > 0) ? GAP : IDLE;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
        GAP: begin
          if (w_last_gap) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CK) begin
    if (CD) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_ptr    <= 2'd0;
      r_strb_n <= 3'b111;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_pend   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_last_strb;
      if (w_start) begin
        r_strb_n <= BCAST ? 3'b000 : ~(3'b100 >> r_ptr);
        if (!BCAST) r_ptr <= (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
      end else if (w_last_strb) begin
        r_strb_n <= 3'b111;
      end
      case ({w_inc, w_from_q})
        2'b10: begin
          if (r_pend == PMAX) r_ovf  <= 1'b1;
          else                r_pend <= r_pend + 3'd1;
        end
        2'b01:   r_pend <= r_pend - 3'd1;
        default: ;
      endcase
    end
  end

  assign {AN, BN, CN} = r_strb_n;
  assign BUSY = r_busy;
  assign DONE = r_done;
  assign OVF  = r_ovf;
  assign PEND = r_pend;
endmodule

// File: tb/tb_g_3strb_seq.sv
// Bench for g_3strb_seq: two parameterisations driven in lockstep and checked against
// a timestamp-based model (strobe start cycle, queue count, round-robin index).
module tb_g_3strb_seq;
  logic CK = 1'b0, CD = 1'b0, Y = 1'b0, BCAST = 1'b0;
  logic an_a, bn_a, cn_a, busy_a, done_a, ovf_a;
  logic an_b, bn_b, cn_b, busy_b, done_b, ovf_b;
  logic [2:0] pend_a, pend_b;

  always #5 CK = ~CK;

  g_3strb_seq #(.PULSE_W(2), .GAP_W(1), .PEND_MAX(3)) u_a (
    .CK(CK), .CD(CD), .Y(Y), .BCAST(BCAST), .AN(an_a), .BN(bn_a), .CN(cn_a),
    .BUSY(busy_a), .DONE(done_a), .OVF(ovf_a), .PEND(pend_a));
  g_3strb_seq #(.PULSE_W(3), .GAP_W(0), .PEND_MAX(2)) u_b (
    .CK(CK), .CD(CD), .Y(Y), .BCAST(BCAST), .AN(an_b), .BN(bn_b), .CN(cn_b),
    .BUSY(busy_b), .DONE(done_b), .OVF(ovf_b), .PEND(pend_b));

  wire [8:0] va = {an_a, bn_a, cn_a, busy_a, done_a, ovf_a, pend_a};
  wire [8:0] vb = {an_b, bn_b, cn_b, busy_b, done_b, ovf_b, pend_b};
  localparam logic [8:0] RST_V = 9'b111_0_0_0_000;

  int checks = 0, failures = 0;

  // Model: per instance, time-stamped strobe/done events plus queue and pointer.
  localparam int P[2] = '{2, 3};
  localparam int G[2] = '{1, 0};
  localparam int M[2] = '{3, 2};
  int n = 0;
  int s[2], pend[2], ptr[2], d0[2], d1[2], nstart[2];
  bit act[2], ovf[2];
  logic [2:0] mk[2];

  task automatic model_edge(input bit y, input bit bc, input bit cd);
    for (int k = 0; k < 2; k++) begin
      if (cd) begin
        act[k] = 0; pend[k] = 0; ovf[k] = 0; ptr[k] = 0; d0[k] = -100; d1[k] = -100; mk[k] = 3'b000;
      end else begin
        bit dec;
        dec = !act[k] || (n == s[k] + P[k] + G[k]);
        if (dec && (y || pend[k] > 0)) begin
          if (pend[k] > 0 && !y) pend[k]--;
          s[k] = n; act[k] = 1; nstart[k]++;
          mk[k] = bc ? 3'b111 : (3'b100 >> ptr[k]);
          if (!bc) ptr[k] = (ptr[k] + 1) % 3;
          d0[k] = d1[k]; d1[k] = n + P[k] + 1;
        end else begin
          if (dec) act[k] = 0;
          if (y) begin
            if (pend[k] == M[k]) ovf[k] = 1;
            else pend[k]++;
          end
        end
      end
    end
  endtask

  function automatic logic [8:0] mexp(int k);
    logic [2:0] lo;
    logic b, d;
    lo = 3'b000;
    if (act[k] && n >= s[k] + 1 && n <= s[k] + P[k]) lo = mk[k];
    b = act[k] && (n <= s[k] + P[k] + G[k]);
    d = (n == d0[k]) || (n == d1[k]);
    return {~lo, b, d, ovf[k], 3'(pend[k])};
  endfunction

  task automatic tick(input bit y, input bit bc, input bit cd);
    Y = y; BCAST = bc; CD = cd;
    model_edge(y, bc, cd);
    @(posedge CK); #1;
    n++;
  endtask

  task automatic test_reset();
    tick(0, 0, 1); tick(0, 0, 1);
    checks++;
    if ({va, vb} !== {RST_V, RST_V}) begin
      failures++; $display("FAIL reset got=%b_%b exp=%b_%b", va, vb, RST_V, RST_V);
    end
    checks++;
    if ({va, vb} !== {mexp(0), mexp(1)}) begin
      failures++; $display("FAIL reset_model got=%b_%b exp=%b_%b", va, vb, mexp(0), mexp(1));
    end
  endtask

  task automatic test_single();
    logic [2:0] e;
    tick(0, 0, 1); tick(0, 0, 0); tick(0, 0, 0);
    tick(1, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      e = {(i == 1 || i == 2) ? 1'b0 : 1'b1, 1'b1, 1'b1};
      checks++;
      if ({an_a, bn_a, cn_a, busy_a, done_a} !== {e, i <= 3, i == 3}) begin
        failures++;
        $display("FAIL single i=%0d got=%b exp=%b", i, {an_a, bn_a, cn_a, busy_a, done_a}, {e, i <= 3, i == 3});
      end
      checks++;
      if ({va, vb} !== {mexp(0), mexp(1)}) begin
        failures++; $display("FAIL single_model cyc=%0d got=%b_%b exp=%b_%b", n, va, vb, mexp(0), mexp(1));
      end
      tick(0, 0, 0);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] order [4];
    order[0] = 3'b011; order[1] = 3'b101; order[2] = 3'b110; order[3] = 3'b011;
    tick(0, 0, 1);
    for (int p = 0; p < 4; p++) begin
      tick(1, 0, 0);
      checks++;
      if ({an_a, bn_a, cn_a} !== order[p]) begin
        failures++; $display("FAIL rr p=%0d got=%b exp=%b", p, {an_a, bn_a, cn_a}, order[p]);
      end
      for (int i = 0; i < 9; i++) begin
        checks++;
        if ({va, vb} !== {mexp(0), mexp(1)}) begin
          failures++; $display("FAIL rr_model cyc=%0d got=%b_%b exp=%b_%b", n, va, vb, mexp(0), mexp(1));
        end
        tick(0, 0, 0);
      end
    end
  endtask

  task automatic test_queue_ovf();
    int st0, seen;
    logic prev;
    tick(0, 0, 1);
    st0 = nstart[0]; seen = 0; prev = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(i < 6, 0, 0);
      if (prev && !(an_a & bn_a & cn_a)) seen++;
      prev = an_a & bn_a & cn_a;
      checks++;
      if ({va, vb} !== {mexp(0), mexp(1)}) begin
        failures++; $display("FAIL queue_model cyc=%0d got=%b_%b exp=%b_%b", n, va, vb, mexp(0), mexp(1));
      end
    end
    checks++;
    if (ovf_a !== 1'b1 || pend_a !== 3'd0) begin
      failures++; $display("FAIL queue_end got ovf=%b pend=%0d exp ovf=1 pend=0", ovf_a, pend_a);
    end
    checks++;
    if (seen !== nstart[0] - st0) begin
      failures++; $display("FAIL queue_count got=%0d exp=%0d", seen, nstart[0] - st0);
    end
  endtask

  task automatic test_bcast();
    tick(0, 0, 1);
    tick(1, 0, 0);
    repeat (5) tick(0, 0, 0);
    tick(1, 1, 0);
    checks++;
    if ({an_a, bn_a, cn_a, an_b, bn_b, cn_b} !== 6'b000000) begin
      failures++; $display("FAIL bcast got=%b exp=000000", {an_a, bn_a, cn_a, an_b, bn_b, cn_b});
    end
    repeat (5) begin
      checks++;
      if ({va, vb} !== {mexp(0), mexp(1)}) begin
        failures++; $display("FAIL bcast_model cyc=%0d got=%b_%b exp=%b_%b", n, va, vb, mexp(0), mexp(1));
      end
      tick(0, 0, 0);
    end
    tick(1, 0, 0);
    checks++;
    if ({an_a, bn_a, cn_a} !== 3'b101) begin
      failures++; $display("FAIL bcast_ptr got=%b exp=101", {an_a, bn_a, cn_a});
    end
  endtask

  task automatic test_abort();
    tick(0, 0, 1);
    tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 1);
    checks++;
    if ({va, vb} !== {RST_V, RST_V}) begin
      failures++; $display("FAIL abort got=%b_%b exp=%b_%b", va, vb, RST_V, RST_V);
    end
    tick(1, 0, 0);
    checks++;
    if ({an_a, bn_a, cn_a, an_b, bn_b, cn_b} !== 6'b011011) begin
      failures++; $display("FAIL abort_restart got=%b exp=011011", {an_a, bn_a, cn_a, an_b, bn_b, cn_b});
    end
    repeat (6) tick(0, 0, 0);
  endtask

  task automatic test_back_to_back();
    tick(0, 0, 1);
    tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0); tick(1, 0, 0);
    checks++;
    if ({an_b, bn_b, cn_b, done_b, busy_b} !== 5'b101_1_1) begin
      failures++; $display("FAIL b2b got=%b exp=10111", {an_b, bn_b, cn_b, done_b, busy_b});
    end
    checks++;
    if ({va, vb} !== {mexp(0), mexp(1)}) begin
      failures++; $display("FAIL b2b_model cyc=%0d got=%b_%b exp=%b_%b", n, va, vb, mexp(0), mexp(1));
    end
    repeat (8) tick(0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 9) < 4, $urandom_range(0, 4) == 0, $urandom_range(0, 79) == 0);
      checks++;
      if ({va, vb} !== {mexp(0), mexp(1)}) begin
        failures++; $display("FAIL random cyc=%0d got=%b_%b exp=%b_%b", n, va, vb, mexp(0), mexp(1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_queue_ovf();
    test_bcast();
    test_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
